loop_counter_ctrl: RTL and testbench

- FSM sequencer that drives the 4-bit up-counter through one bounded loop: load start value, step, increment, stop at limit.
- For each counter value it runs a req/ack handshake with the datapath consumer; `done` pulses when the loop ends.
- Sits between the top-level control (`start`/`done`) and the counter and datapath step logic.

---
 rtl/loop_counter_ctrl_if.sv | 22 ++
 rtl/loop_counter_ctrl.sv | 103 ++++++++++
 tb/tb_loop_counter_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_counter_ctrl_if.sv
// Counter/datapath side of loop_counter_ctrl: counter load/increment, counter
// feedback, and the step_req/step_ack handshake.
interface loop_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt_in;
  logic             step_req;
  logic             step_ack;

  modport master (
    output cnt_ld, cnt_data, cnt_inc, step_req,
    input  cnt_in, step_ack
  );

  modport slave (
    input  cnt_ld, cnt_data, cnt_inc, step_req,
    output cnt_in, step_ack
  );
endinterface

// File: rtl/loop_counter_ctrl.sv
// Bounded-loop sequencer: loads the counter, runs one step handshake per value
// up to limit inclusive, then pulses done. Optional stall input: LOOP_CTRL_PAUSE_EN.
module loop_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LOOP_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] limit_val,
  loop_counter_ctrl_if.master dp,
  output logic             busy,
  output logic             done,
  output logic             range_err
);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, CHECK, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] init_r, limit_r;
  logic             err_r;
  logic             stall;
  logic             accept;
  logic             bad_range;

`ifdef LOOP_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign accept    = (state == IDLE) && start && !stall;
  assign bad_range = init_val > limit_val;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      init_r  <= '0;
      limit_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        init_r  <= init_val;
        limit_r <= limit_val;
        err_r   <= bad_range;
      end else if (state == DONE && !stall) begin
        err_r <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state   = state;
    dp.cnt_ld    = 1'b0;
    dp.cnt_data  = '0;
    dp.cnt_inc   = 1'b0;
    dp.step_req  = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    range_err    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) next_state = bad_range ? DONE : LOAD;
      end
      LOAD: begin
        dp.cnt_ld   = !stall;
        dp.cnt_data = init_r;
        next_state  = REQ;
      end
      REQ: begin
        dp.step_req = !stall;
        if (dp.step_ack) next_state = CHECK;
      end
      CHECK: begin
        // Stop at limit without incrementing, so the counter never wraps.
        if (dp.cnt_in == limit_r) begin
          next_state = DONE;
        end else begin
          dp.cnt_inc = !stall;
          next_state = REQ;
        end
      end
      DONE: begin
        done       = 1'b1;
        range_err  = err_r;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (stall) next_state = state;
  end

endmodule

// File: tb/tb_loop_counter_ctrl.sv
// Directed self-checking bench for loop_counter_ctrl with a behavioural counter
// and a configurable ack responder; pause scenario built with LOOP_CTRL_PAUSE_EN.
module tb_loop_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] init_val = '0;
  logic [3:0] limit_val = '0;
  logic       pause = 1'b0;
  logic       busy, done, range_err;
  logic [3:0] cnt = '0;

  loop_counter_ctrl_if #(.WIDTH(4)) dp_if ();

  loop_counter_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LOOP_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .start     (start),
    .init_val  (init_val),
    .limit_val (limit_val),
    .dp        (dp_if),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit up-counter fed by the controller.
  always @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (dp_if.cnt_ld) cnt <= dp_if.cnt_data;
    else if (dp_if.cnt_inc) cnt <= cnt + 4'd1;
  end
  assign dp_if.cnt_in = cnt;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int ack_tied = 1, ack_delay = 0, req_run = 0;
  int pause_from = 1 << 30, pause_len = 0;
  int n_ld, n_inc, n_req, n_hs, n_done, n_rerr, n_rerr_alone, n_bad_data;
  int n_req_paused, n_busy_paused;
  int ld_cyc, req_cyc, done_cyc;
  logic [3:0] ld_data;
  logic [3:0] hs_vals [32];

  // Per-cycle monitor: drive pause and ack for this cycle, then sample outputs.
  always @(posedge clk) begin
    #1;
    cyc++;
    pause = (cyc >= pause_from) && (cyc < pause_from + pause_len);
    #1;
    if (ack_tied != 0) begin
      dp_if.step_ack = 1'b1;
    end else if (dp_if.step_req) begin
      req_run++;
      dp_if.step_ack = (req_run > ack_delay);
    end else begin
      req_run = 0;
      dp_if.step_ack = 1'b0;
    end
    #1;
    if (dp_if.cnt_ld) begin
      if (n_ld == 0) ld_cyc = cyc;
      ld_data = dp_if.cnt_data;
      n_ld++;
    end
    if (!dp_if.cnt_ld && dp_if.cnt_data != 4'd0) n_bad_data++;
    if (dp_if.cnt_inc) n_inc++;
    if (dp_if.step_req) begin
      if (n_req == 0) req_cyc = cyc;
      n_req++;
      if (pause) n_req_paused++;
      if (dp_if.step_ack) begin
        if (n_hs < 32) hs_vals[n_hs] = dp_if.cnt_in;
        n_hs++;
      end
    end
    if (pause && busy) n_busy_paused++;
    if (done) begin
      if (n_done == 0) done_cyc = cyc;
      n_done++;
    end
    if (range_err) begin
      n_rerr++;
      if (!done) n_rerr_alone++;
    end
  end

  task automatic clear_counts();
    n_ld = 0; n_inc = 0; n_req = 0; n_hs = 0; n_done = 0; n_rerr = 0;
    n_rerr_alone = 0; n_req_paused = 0; n_busy_paused = 0;
    ld_cyc = -1; req_cyc = -1; done_cyc = -1; ld_data = '0;
  endtask

  // Pulse start for one cycle; n is the cycle in which start is sampled.
  task automatic kick(input logic [3:0] i, input logic [3:0] l, output int n);
    @(negedge clk);
    start = 1'b1; init_val = i; limit_val = l;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (n_done > 0) break;
      @(negedge clk);
    end
    n_assert++;
    if (n_done == 0) begin
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    dp_if.step_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      outs = {busy, done, range_err, dp_if.cnt_ld, dp_if.cnt_inc, dp_if.step_req, dp_if.cnt_data};
      n_assert++;
      if (outs !== 10'd0) begin
        $display("FAIL reset_idle[%0d]: outputs=%b expected all zero", i, outs);
        n_fail++;
      end
    end
  endtask

  task automatic test_basic();
    int n;
    clear_counts();
    ack_tied = 1;
    kick(4'd3, 4'd6, n);
    wait_done(40, "basic");
    @(negedge clk);
    n_assert++; if (n_ld !== 1)        begin $display("FAIL basic_ld_count: got %0d need 1", n_ld); n_fail++; end
    n_assert++; if (ld_data !== 4'd3)  begin $display("FAIL basic_ld_data: got %0d need 3", ld_data); n_fail++; end
    n_assert++; if (ld_cyc !== n + 1)  begin $display("FAIL basic_ld_latency: got %0d need %0d", ld_cyc, n + 1); n_fail++; end
    n_assert++; if (req_cyc !== n + 2) begin $display("FAIL basic_req_latency: got %0d need %0d", req_cyc, n + 2); n_fail++; end
    n_assert++; if (n_hs !== 4)        begin $display("FAIL basic_handshakes: got %0d need 4", n_hs); n_fail++; end
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (hs_vals[k] !== 4'(3 + k)) begin
        $display("FAIL basic_step_value[%0d]: got %0d need %0d", k, hs_vals[k], 3 + k); n_fail++;
      end
    end
    n_assert++; if (n_inc !== 3)         begin $display("FAIL basic_inc_count: got %0d need 3", n_inc); n_fail++; end
    n_assert++; if (n_done !== 1)        begin $display("FAIL basic_done_count: got %0d need 1", n_done); n_fail++; end
    n_assert++; if (done_cyc !== n + 10) begin $display("FAIL basic_done_latency: got %0d need %0d", done_cyc, n + 10); n_fail++; end
    n_assert++; if (n_rerr !== 0)        begin $display("FAIL basic_range_err: got %0d need 0", n_rerr); n_fail++; end
    n_assert++; if (busy !== 1'b0)       begin $display("FAIL basic_busy_after: got %b need 0", busy); n_fail++; end
  endtask

  task automatic test_delayed_ack();
    int n;
    clear_counts();
    ack_tied = 0; ack_delay = 3;
    kick(4'd5, 4'd5, n);
    wait_done(40, "delayed");
    @(negedge clk);
    n_assert++; if (n_req !== 4)        begin $display("FAIL delayed_req_cycles: got %0d need 4", n_req); n_fail++; end
    n_assert++; if (n_hs !== 1)         begin $display("FAIL delayed_handshakes: got %0d need 1", n_hs); n_fail++; end
    n_assert++; if (hs_vals[0] !== 4'd5) begin $display("FAIL delayed_step_value: got %0d need 5", hs_vals[0]); n_fail++; end
    n_assert++; if (n_inc !== 0)        begin $display("FAIL delayed_inc_count: got %0d need 0", n_inc); n_fail++; end
    n_assert++; if (n_done !== 1)       begin $display("FAIL delayed_done_count: got %0d need 1", n_done); n_fail++; end
    n_assert++; if (done_cyc !== n + 7) begin $display("FAIL delayed_done_latency: got %0d need %0d", done_cyc, n + 7); n_fail++; end
    ack_tied = 1;
  endtask

  task automatic test_range_err();
    int n;
    clear_counts();
    kick(4'd9, 4'd2, n);
    wait_done(10, "range");
    repeat (2) @(negedge clk);
    n_assert++; if (done_cyc !== n + 1) begin $display("FAIL range_done_latency: got %0d need %0d", done_cyc, n + 1); n_fail++; end
    n_assert++; if (n_done !== 1)       begin $display("FAIL range_done_count: got %0d need 1", n_done); n_fail++; end
    n_assert++; if (n_rerr !== 1)       begin $display("FAIL range_err_count: got %0d need 1", n_rerr); n_fail++; end
    n_assert++; if (n_ld + n_inc + n_req !== 0) begin
      $display("FAIL range_no_activity: ld=%0d inc=%0d req=%0d need all 0", n_ld, n_inc, n_req); n_fail++;
    end
  endtask

  task automatic test_full_range();
    int n;
    clear_counts();
    kick(4'd0, 4'd15, n);
    // Start pulses with different operands while busy must be ignored.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_done > 0) break;
      start = (i % 5 == 2); init_val = 4'd7; limit_val = 4'd9;
    end
    start = 1'b0;
    wait_done(5, "full");
    repeat (3) @(negedge clk);
    n_assert++; if (n_hs !== 16)         begin $display("FAIL full_handshakes: got %0d need 16", n_hs); n_fail++; end
    n_assert++; if (n_inc !== 15)        begin $display("FAIL full_inc_count: got %0d need 15", n_inc); n_fail++; end
    n_assert++; if (n_ld !== 1)          begin $display("FAIL full_ld_count: got %0d need 1", n_ld); n_fail++; end
    n_assert++; if (cnt !== 4'd15)       begin $display("FAIL full_counter_end: got %0d need 15", cnt); n_fail++; end
    n_assert++; if (hs_vals[15] !== 4'd15) begin $display("FAIL full_last_step: got %0d need 15", hs_vals[15]); n_fail++; end
    n_assert++; if (done_cyc !== n + 34) begin $display("FAIL full_done_latency: got %0d need %0d", done_cyc, n + 34); n_fail++; end
    n_assert++; if (n_done !== 1)        begin $display("FAIL full_done_count: got %0d need 1", n_done); n_fail++; end
    n_assert++; if (busy !== 1'b0)       begin $display("FAIL full_no_requeue: busy=%b need 0", busy); n_fail++; end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_counts();
    ack_tied = 0; ack_delay = 1000;
    kick(4'd1, 4'd8, n);
    for (int i = 0; i < 10; i++) begin
      if (dp_if.step_req) break;
      @(negedge clk);
    end
    n_assert++; if (dp_if.step_req !== 1'b1) begin $display("FAIL rstmid_in_req: step_req=%b need 1", dp_if.step_req); n_fail++; end
    reset = 1'b1;
    @(negedge clk);
    n_assert++; if (dp_if.step_req !== 1'b0) begin $display("FAIL rstmid_req_drop: step_req=%b need 0", dp_if.step_req); n_fail++; end
    n_assert++; if (busy !== 1'b0)           begin $display("FAIL rstmid_idle: busy=%b need 0", busy); n_fail++; end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_assert++; if (n_done !== 0) begin $display("FAIL rstmid_no_done: got %0d need 0", n_done); n_fail++; end
    n_assert++; if (busy !== 1'b0) begin $display("FAIL rstmid_stays_idle: busy=%b need 0", busy); n_fail++; end
    ack_tied = 1; ack_delay = 0;
  endtask

`ifdef LOOP_CTRL_PAUSE_EN
  task automatic test_pause();
    int n;
    clear_counts();
    ack_tied = 1;
    kick(4'd2, 4'd4, n);
    pause_from = n + 2; pause_len = 3;
    wait_done(40, "pause");
    @(negedge clk);
    pause_from = 1 << 30; pause_len = 0;
    n_assert++; if (n_req_paused !== 0)  begin $display("FAIL pause_req_low: got %0d need 0", n_req_paused); n_fail++; end
    n_assert++; if (n_busy_paused !== 3) begin $display("FAIL pause_busy_held: got %0d need 3", n_busy_paused); n_fail++; end
    n_assert++; if (n_hs !== 3)          begin $display("FAIL pause_handshakes: got %0d need 3", n_hs); n_fail++; end
    n_assert++; if (n_inc !== 2)         begin $display("FAIL pause_inc_count: got %0d need 2", n_inc); n_fail++; end
    n_assert++; if (done_cyc !== n + 11) begin $display("FAIL pause_done_latency: got %0d need %0d", done_cyc, n + 11); n_fail++; end
  endtask
`endif

  initial begin
    n_bad_data = 0;
    clear_counts();
    test_reset();
    test_basic();
    repeat (2) @(negedge clk);
    test_delayed_ack();
    repeat (2) @(negedge clk);
    test_range_err();
    repeat (2) @(negedge clk);
    test_full_range();
    repeat (2) @(negedge clk);
    test_reset_mid();
`ifdef LOOP_CTRL_PAUSE_EN
    repeat (2) @(negedge clk);
    test_pause();
`endif
    n_assert++; if (n_bad_data !== 0) begin $display("FAIL cnt_data_outside_load: got %0d cycles need 0", n_bad_data); n_fail++; end
    n_assert++; if (n_rerr_alone !== 0) begin $display("FAIL range_err_without_done: got %0d cycles need 0", n_rerr_alone); n_fail++; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
